// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the RV32 multicycle main controller: FSM state
// enumeration, opcode constants and the encodings of every datapath select
// driven by the controller.
// Optional feature macro used by the controller: MC_AUIPC_EN (AUIPC support).
package mc_ctrl_pkg;

   // Controller states, one per datapath cycle
   typedef enum logic [3:0] {
      st_fetch,
      st_decode,
      st_memadr,
      st_memread,
      st_memwb,
      st_memwrite,
      st_execr,
      st_execi,
      st_aluwb,
      st_branch,
      st_jal,
      st_jalr,
      st_lui,
      st_auipc,
      st_halt
   } mc_state_e;

   // RV32 opcodes
   localparam logic [6:0] op_load   = 7'b0000011;
   localparam logic [6:0] op_store  = 7'b0100011;
   localparam logic [6:0] op_rtype  = 7'b0110011;
   localparam logic [6:0] op_itype  = 7'b0010011;
   localparam logic [6:0] op_branch = 7'b1100011;
   localparam logic [6:0] op_jal    = 7'b1101111;
   localparam logic [6:0] op_jalr   = 7'b1100111;
   localparam logic [6:0] op_lui    = 7'b0110111;
   localparam logic [6:0] op_auipc  = 7'b0010111;

   // ALUControl encodings
   localparam logic [2:0] alu_add  = 3'b000;
   localparam logic [2:0] alu_sub  = 3'b001;
   localparam logic [2:0] alu_and  = 3'b010;
   localparam logic [2:0] alu_or   = 3'b011;
   localparam logic [2:0] alu_slt  = 3'b100;
   localparam logic [2:0] alu_sltu = 3'b101;
   localparam logic [2:0] alu_xor  = 3'b110;
   localparam logic [2:0] alu_br   = 3'b111;

   // ImmSrc encodings
   localparam logic [2:0] imm_i = 3'b000;
   localparam logic [2:0] imm_s = 3'b001;
   localparam logic [2:0] imm_b = 3'b010;
   localparam logic [2:0] imm_j = 3'b011;
   localparam logic [2:0] imm_u = 3'b100;

   // ResultSrc encodings
   localparam logic [1:0] res_aluout    = 2'b00;
   localparam logic [1:0] res_data      = 2'b01;
   localparam logic [1:0] res_aluresult = 2'b10;
   localparam logic [1:0] res_immext    = 2'b11;

   // ALUSrcA encodings
   localparam logic [1:0] srca_pc    = 2'b00;
   localparam logic [1:0] srca_oldpc = 2'b01;
   localparam logic [1:0] srca_a     = 2'b10;

   // ALUSrcB encodings
   localparam logic [1:0] srcb_wd   = 2'b00;
   localparam logic [1:0] srcb_imm  = 2'b01;
   localparam logic [1:0] srcb_four = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder
// Combinational ALU decode for R-type and I-type arithmetic instructions.
// Ports:
//   op5        in  1 : OP[5]; 1 = R-type (funct7 checked), 0 = I-type
//   funct3     in  3 : instruction funct3
//   funct7     in  7 : instruction funct7
//   ALUControl out 3 : ALU operation
//   illegal    out 1 : encoding not supported (shifts, bad funct7)
module mc_alu_decoder
   import mc_ctrl_pkg::*;
(
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [2:0] ALUControl,
   output logic       illegal
);

   logic f7_bad_s;

   // Non-zero funct7 only matters for R-type
   assign f7_bad_s = op5 & (funct7 != 7'b0000000);

   // funct3/funct7 to ALU operation map
   always_comb begin
      ALUControl = alu_add;
      illegal    = 1'b0;
      case (funct3)
         3'b000: begin
            if (!op5) begin
               ALUControl = alu_add;
            end else if (funct7 == 7'b0000000) begin
               ALUControl = alu_add;
            end else if (funct7 == 7'b0100000) begin
               ALUControl = alu_sub;
            end else begin
               illegal = 1'b1;
            end
         end
         3'b010: begin
            ALUControl = alu_slt;
            illegal    = f7_bad_s;
         end
         3'b011: begin
            ALUControl = alu_sltu;
            illegal    = f7_bad_s;
         end
         3'b100: begin
            ALUControl = alu_xor;
            illegal    = f7_bad_s;
         end
         3'b110: begin
            ALUControl = alu_or;
            illegal    = f7_bad_s;
         end
         3'b111: begin
            ALUControl = alu_and;
            illegal    = f7_bad_s;
         end
         // 001 and 101 are shifts, which this datapath does not implement
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller
// Main FSM of the RV32 multicycle CPU. Sequences the datapath one state per
// cycle and drives every write enable and mux select.
// Optional feature: define MC_AUIPC_EN to execute AUIPC (otherwise it halts).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   OP, funct3, funct7       : instruction fields (stable from DECODE onward)
//   Zero                     : ALU flag, branch taken when 1
//   regWrite, PCWrite, MemWrite, IRWrite, PC4Write : write enables
//   AdrSrc, WD3Src, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl : selects
//   halt                     : sticky, set after an unsupported instruction
module multi_cycle_controller
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] OP,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       Zero,
   output logic       regWrite,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PC4Write,
   output logic       AdrSrc,
   output logic       WD3Src,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       halt
);

   mc_state_e  state_r;
   mc_state_e  decode_next_s;
   logic [2:0] dec_alu_s;
   logic       dec_illegal_s;

   mc_alu_decoder u_alu_decoder (
      .op5        (OP[5]),
      .funct3     (funct3),
      .funct7     (funct7),
      .ALUControl (dec_alu_s),
      .illegal    (dec_illegal_s)
   );

   // Opcode dispatch out of DECODE; illegal ALU encodings go to HALT
   always_comb begin
      decode_next_s = st_halt;
      case (OP)
         op_load, op_store: decode_next_s = st_memadr;
         op_rtype:          decode_next_s = dec_illegal_s ? st_halt : st_execr;
         op_itype:          decode_next_s = dec_illegal_s ? st_halt : st_execi;
         op_branch:         decode_next_s = st_branch;
         op_jal:            decode_next_s = st_jal;
         op_jalr:           decode_next_s = st_jalr;
         op_lui:            decode_next_s = st_lui;
`ifdef MC_AUIPC_EN
         op_auipc:          decode_next_s = st_auipc;
`else
`endif
         default:           decode_next_s = st_halt;
      endcase
   end

   // State register; unknown encodings fall into HALT
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= st_fetch;
      end else begin
         case (state_r)
            st_fetch:    state_r <= st_decode;
            st_decode:   state_r <= decode_next_s;
            st_memadr:   state_r <= OP[5] ? st_memwrite : st_memread;
            st_memread:  state_r <= st_memwb;
            st_execr,
            st_execi,
            st_auipc:    state_r <= st_aluwb;
            st_memwb,
            st_memwrite,
            st_aluwb,
            st_branch,
            st_jal,
            st_jalr,
            st_lui:      state_r <= st_fetch;
            st_halt:     state_r <= st_halt;
            default:     state_r <= st_halt;
         endcase
      end
   end

   // Moore output decode from the state register. Outputs must be valid in
   // the same cycle the state is entered, and PCWrite in BRANCH follows Zero
   // within the cycle, so this decode is not delayed by another register.
   // While rst is high everything is forced to zero, so an instruction
   // aborted by reset performs no further writes.
   always_comb begin
      regWrite   = 1'b0;
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PC4Write   = 1'b0;
      AdrSrc     = 1'b0;
      WD3Src     = 1'b0;
      ResultSrc  = res_aluout;
      ALUSrcA    = srca_pc;
      ALUSrcB    = srcb_wd;
      ImmSrc     = imm_i;
      ALUControl = alu_add;
      halt       = 1'b0;
      if (rst) begin
         halt = 1'b0;
      end else begin
         case (state_r)
            st_fetch: begin
               IRWrite   = 1'b1;
               ALUSrcB   = srcb_four;
               ResultSrc = res_aluresult;
               PCWrite   = 1'b1;
               PC4Write  = 1'b1;
            end
            // Branch target is computed speculatively into ALUOut
            st_decode: begin
               ALUSrcA = srca_oldpc;
               ALUSrcB = srcb_imm;
               ImmSrc  = imm_b;
            end
            st_memadr: begin
               ALUSrcA = srca_a;
               ALUSrcB = srcb_imm;
               ImmSrc  = OP[5] ? imm_s : imm_i;
            end
            st_memread: begin
               AdrSrc = 1'b1;
            end
            st_memwb: begin
               ResultSrc = res_data;
               regWrite  = 1'b1;
            end
            st_memwrite: begin
               AdrSrc   = 1'b1;
               MemWrite = 1'b1;
            end
            st_execr: begin
               ALUSrcA    = srca_a;
               ALUControl = dec_alu_s;
            end
            st_execi: begin
               ALUSrcA    = srca_a;
               ALUSrcB    = srcb_imm;
               ALUControl = dec_alu_s;
            end
            st_aluwb: begin
               regWrite = 1'b1;
            end
            st_branch: begin
               ALUSrcA    = srca_a;
               ALUControl = alu_br;
               PCWrite    = Zero;
            end
            st_jal: begin
               ALUSrcA   = srca_oldpc;
               ALUSrcB   = srcb_imm;
               ImmSrc    = imm_j;
               ResultSrc = res_aluresult;
               PCWrite   = 1'b1;
               regWrite  = 1'b1;
               WD3Src    = 1'b1;
            end
            // rd==rs1 is safe: A was latched in DECODE, before the write
            st_jalr: begin
               ALUSrcA   = srca_a;
               ALUSrcB   = srcb_imm;
               ImmSrc    = imm_i;
               ResultSrc = res_aluresult;
               PCWrite   = 1'b1;
               regWrite  = 1'b1;
               WD3Src    = 1'b1;
            end
            st_lui: begin
               ImmSrc    = imm_u;
               ResultSrc = res_immext;
               regWrite  = 1'b1;
            end
            st_auipc: begin
               ALUSrcA = srca_oldpc;
               ALUSrcB = srcb_imm;
               ImmSrc  = imm_u;
            end
            st_halt: begin
               halt = 1'b1;
            end
            default: begin
               halt = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller
// Self-checking bench: directed instructions from the test plan followed by
// randomized instructions. For each instruction the expected per-cycle
// output bundle is listed from the instruction-level tables and compared
// cycle by cycle.
module tb_multi_cycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] OP;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       Zero;
   logic       regWrite, PCWrite, MemWrite, IRWrite, PC4Write, AdrSrc, WD3Src;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc, ALUControl;
   logic       halt;

   always #5 clk = ~clk;

   multi_cycle_controller dut (
      .clk(clk), .rst(rst), .OP(OP), .funct3(funct3), .funct7(funct7), .Zero(Zero),
      .regWrite(regWrite), .PCWrite(PCWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .PC4Write(PC4Write), .AdrSrc(AdrSrc), .WD3Src(WD3Src), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .halt(halt)
   );

   // Bundle bit 18 is PCWrite
   logic [19:0] obs;
   assign obs = {regWrite, PCWrite, MemWrite, IRWrite, PC4Write, AdrSrc, WD3Src,
                 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, halt};

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic check_vec(input string tag, input logic [19:0] got, input logic [19:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] mk(input logic rw, input logic pcw, input logic mw,
                                      input logic irw, input logic pc4, input logic adr,
                                      input logic wd3, input logic [1:0] res,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] imm, input logic [2:0] alu,
                                      input logic h);
      return {rw, pcw, mw, irw, pc4, adr, wd3, res, sa, sb, imm, alu, h};
   endfunction

   // ALU operation and legality straight from the funct3/funct7 tables
   function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic [6:0] f7, input logic is_r);
      case (f3)
         3'd0:    return (is_r && f7 == 7'h20) ? 3'b001 : 3'b000;
         3'd2:    return 3'b100;
         3'd3:    return 3'b101;
         3'd4:    return 3'b110;
         3'd6:    return 3'b011;
         3'd7:    return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic bit alu_legal(input logic [2:0] f3, input logic [6:0] f7, input logic is_r);
      if (f3 == 3'd1 || f3 == 3'd5) return 1'b0;
      if (!is_r) return 1'b1;
      return (f7 == 7'h00) || (f3 == 3'd0 && f7 == 7'h20);
   endfunction

   logic [19:0] exp_q[$];
   int          br_idx;
   bit          halts;

   localparam logic [19:0] V_ZERO = 20'h00000;
   localparam logic [19:0] V_HALT = 20'h00001;

   // Build the expected cycle sequence for one instruction
   task automatic plan_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      logic [19:0] aluwb;
      aluwb = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
      exp_q.delete();
      br_idx = -1;
      halts  = 1'b0;
      exp_q.push_back(mk(0, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 0));
      case (op)
         7'b0000011: begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
            exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));
         end
         7'b0100011: begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0));
            exp_q.push_back(mk(0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
         end
         7'b0110011: begin
            if (alu_legal(f3, f7, 1'b1)) begin
               exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, exp_alu(f3, f7, 1'b1), 0));
               exp_q.push_back(aluwb);
            end else begin
               halts = 1'b1;
            end
         end
         7'b0010011: begin
            if (alu_legal(f3, f7, 1'b0)) begin
               exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, exp_alu(f3, f7, 1'b0), 0));
               exp_q.push_back(aluwb);
            end else begin
               halts = 1'b1;
            end
         end
         7'b1100011: begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b111, 0));
            br_idx = exp_q.size() - 1;
         end
         7'b1101111: exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b01, 3'b011, 3'b000, 0));
         7'b1100111: exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000, 0));
         7'b0110111: exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'b100, 3'b000, 0));
`ifdef MC_AUIPC_EN
         7'b0010111: begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b100, 3'b000, 0));
            exp_q.push_back(aluwb);
         end
`endif
         default: halts = 1'b1;
      endcase
   endtask

   // Apply one instruction starting in its FETCH cycle (caller sits 1ns after
   // a rising edge). zmode: 0 random Zero, 1 forced 1, 2 forced 0.
   // abort_at >= 0 asserts rst in that step instead of finishing.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input int zmode, input int abort_at, input string name);
      logic [19:0] e;
      plan_instr(op, f3, f7);
      OP = op;
      funct3 = f3;
      funct7 = f7;
      for (int k = 0; k < exp_q.size(); k++) begin
         Zero = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
         if (k == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            check_vec($sformatf("%s abort_rst", name), obs, V_ZERO);
            @(posedge clk);
            #1;
            rst = 1'b0;
            return;
         end
         e = exp_q[k];
         if (k == br_idx) e[18] = Zero;
         @(negedge clk);
         check_vec($sformatf("%s op=%07b f3=%0d f7=%02h step%0d", name, op, f3, f7, k), obs, e);
         @(posedge clk);
         #1;
      end
      if (halts) begin
         for (int c = 0; c < 20; c++) begin
            Zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_vec($sformatf("%s halted cyc%0d", name, c), obs, V_HALT);
            @(posedge clk);
            #1;
         end
         rst = 1'b1;
         for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_vec($sformatf("%s rst_after_halt%0d", name, c), obs, V_ZERO);
            @(posedge clk);
            #1;
         end
         rst = 1'b0;
      end
   endtask

   logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

   initial begin
      rst = 1'b1;
      OP = 7'b0110011;
      funct3 = 3'b000;
      funct7 = 7'b0100000;
      Zero = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_vec($sformatf("reset cyc%0d", c), obs, V_ZERO);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;

      run_instr(7'b0110011, 3'b000, 7'b0100000, 0, -1, "r_sub");
      run_instr(7'b0000011, 3'b010, 7'h00, 0, -1, "lw");
      run_instr(7'b0100011, 3'b010, 7'h00, 0, -1, "sw");
      run_instr(7'b1100011, 3'b000, 7'h00, 1, -1, "beq_z1");
      run_instr(7'b1100011, 3'b000, 7'h00, 2, -1, "beq_z0");
      run_instr(7'b1101111, 3'b000, 7'h00, 0, -1, "jal");
      run_instr(7'b1100111, 3'b000, 7'h00, 0, -1, "jalr");
      run_instr(7'b0110111, 3'b000, 7'h00, 0, -1, "lui");
      run_instr(7'b0010011, 3'b110, 7'h55, 0, -1, "ori");
      run_instr(7'b0010111, 3'b000, 7'h00, 0, -1, "auipc");
      run_instr(7'b0110011, 3'b001, 7'h00, 0, -1, "r_sll");
      run_instr(7'b0110011, 3'b000, 7'h00, 0, -1, "r_add");
      run_instr(7'b0100011, 3'b010, 7'h00, 0, 2, "sw_abort");
      run_instr(7'b0000011, 3'b010, 7'h00, 0, -1, "lw_after_abort");

      for (int n = 0; n < 300; n++) begin
         logic [6:0] op;
         logic [2:0] f3;
         logic [6:0] f7;
         int         cls;
         cls = $urandom_range(0, 9);
         f3 = 3'($urandom);
         f7 = 7'($urandom);
         case (cls)
            0: begin op = 7'b0000011; f3 = 3'b010; end
            1: begin op = 7'b0100011; f3 = 3'b010; end
            2, 3: begin
               op = 7'b0110011;
               case ($urandom_range(0, 3))
                  0, 2:    f7 = 7'h00;
                  1:       f7 = 7'h20;
                  default: f7 = 7'($urandom);
               endcase
            end
            4: op = 7'b0010011;
            5: begin op = 7'b1100011; f3 = br_f3[$urandom_range(0, 5)]; end
            6: op = 7'b1101111;
            7: begin op = 7'b1100111; f3 = 3'b000; end
            8: op = 7'b0110111;
            default: op = {5'($urandom), 2'($urandom_range(0, 2))};
         endcase
         run_instr(op, f3, f7, 0, -1, "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
